// File: rtl/axis_rng_range_if.sv
// axis_rng_range_if: stream, bound-load and status signals of the range sampler
interface axis_rng_range_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] input_axis_tdata;
  logic                  input_axis_tvalid;
  logic                  input_axis_tready;
  logic [OUT_WIDTH-1:0]  output_axis_tdata;
  logic                  output_axis_tvalid;
  logic                  output_axis_tready;
  logic [OUT_WIDTH-1:0]  bound;
  logic                  bound_load;
  logic                  busy;
  logic [31:0]           reject_count;
  modport slave (
    input  input_axis_tdata, input_axis_tvalid, output_axis_tready, bound, bound_load,
    output input_axis_tready, output_axis_tdata, output_axis_tvalid, busy, reject_count
  );
  modport master (
    output input_axis_tdata, input_axis_tvalid, output_axis_tready, bound, bound_load,
    input  input_axis_tready, output_axis_tdata, output_axis_tvalid, busy, reject_count
  );
endinterface

// File: rtl/axis_rng_range.sv
// axis_rng_range: mask-and-reject sampler mapping random words onto [0, bound]
module axis_rng_range #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 32
) (
  input logic            clk,
  input logic            rst,
  axis_rng_range_if.slave s
);
  if (OUT_WIDTH > DATA_WIDTH) begin : g_width_check
    $error("OUT_WIDTH must not exceed DATA_WIDTH");
  end
  typedef enum logic [1:0] {IDLE, PEND, CALC, RUN} state_t;
  state_t               state, state_nx;
  logic [OUT_WIDTH-1:0] mask, bound_reg, cand, tdata;
  logic [31:0]          rej;
  logic                 tvalid, in_hs, out_hs, pass, calc_entry;
  assign cand       = s.input_axis_tdata[OUT_WIDTH-1:0] & mask;
  assign pass       = cand <= bound_reg;
  assign out_hs     = tvalid && s.output_axis_tready;
  assign in_hs      = s.input_axis_tvalid && s.input_axis_tready;
  assign calc_entry = state == PEND && state_nx == CALC;
  assign s.input_axis_tready  = state == RUN && (!tvalid || s.output_axis_tready);
  assign s.output_axis_tdata  = tdata;
  assign s.output_axis_tvalid = tvalid;
  assign s.busy               = state == PEND || state == CALC;
  assign s.reject_count       = rej;
  always_comb begin
    state_nx = s.bound_load                                              ? PEND :
               (state == PEND && (!tvalid || s.output_axis_tready))      ? CALC :
               (state == CALC && mask >= bound_reg)                      ? RUN  : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bound_reg <= '0;
      mask      <= '0;
      rej       <= '0;
      tdata     <= '0;
      tvalid    <= 1'b0;
    end else begin
      if (s.bound_load) bound_reg <= s.bound;
      if (calc_entry) mask <= '0;
      else if (state == CALC && mask < bound_reg) mask <= (mask << 1) | OUT_WIDTH'(1);
      if (calc_entry) rej <= '0;
      else if (in_hs && !pass && rej != '1) rej <= rej + 32'd1;
      if (in_hs && pass) begin
        tdata  <= cand;
        tvalid <= 1'b1;
      end else if (out_hs) tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_rng_range.sv
// tb_axis_rng_range: directed checks of load timing, sampling, backpressure and reset
module tb_axis_rng_range;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n;
  axis_rng_range_if ifc ();
  axis_rng_range dut (.clk(clk), .rst(rst), .s(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] b);
    ifc.bound = b;
    ifc.bound_load = 1'b1;
    cyc();
    ifc.bound_load = 1'b0;
    chk("busy_after_load", ifc.busy, 1);
  endtask
  task automatic busy_len(input string tag, input int e);
    n = 0;
    while (ifc.busy && n < 100) begin
      n++;
      cyc();
    end
    chk(tag, n, e);
  endtask
  task automatic send(input logic [63:0] d);
    ifc.input_axis_tdata = d;
    ifc.input_axis_tvalid = 1'b1;
    cyc();
    ifc.input_axis_tvalid = 1'b0;
  endtask
  initial begin
    ifc.input_axis_tdata = '0;
    ifc.input_axis_tvalid = 1'b0;
    ifc.output_axis_tready = 1'b0;
    ifc.bound = '0;
    ifc.bound_load = 1'b0;
    #2;
    chk("rst_tready", ifc.input_axis_tready, 0);
    chk("rst_tvalid", ifc.output_axis_tvalid, 0);
    chk("rst_tdata", ifc.output_axis_tdata, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_rej", ifc.reject_count, 0);
    #1 rst = 1'b1;
    ifc.input_axis_tvalid = 1'b1;
    ifc.input_axis_tdata = 64'h5;
    cyc(); cyc(); cyc();
    chk("idle_tready", ifc.input_axis_tready, 0);
    chk("idle_tvalid", ifc.output_axis_tvalid, 0);
    ifc.input_axis_tvalid = 1'b0;
    ifc.output_axis_tready = 1'b1;
    load(32'd5);
    busy_len("busy_len_5", 5);
    chk("run_tready", ifc.input_axis_tready, 1);
    send(64'h3);
    chk("b5_out3", ifc.output_axis_tdata, 3);
    chk("b5_v3", ifc.output_axis_tvalid, 1);
    send(64'h6);
    chk("b5_rej_v", ifc.output_axis_tvalid, 0);
    chk("b5_rej_cnt", ifc.reject_count, 1);
    send(64'hD);
    chk("b5_out5", ifc.output_axis_tdata, 5);
    send(64'hFFFFFFFF_FFFFFF0C);
    chk("b5_out4", ifc.output_axis_tdata, 4);
    chk("b5_v4", ifc.output_axis_tvalid, 1);
    cyc();
    chk("b5_drain", ifc.output_axis_tvalid, 0);
    chk("b5_rej_final", ifc.reject_count, 1);
    ifc.output_axis_tready = 1'b0;
    ifc.input_axis_tdata = 64'h1;
    ifc.input_axis_tvalid = 1'b1;
    cyc();
    chk("bp_out1", ifc.output_axis_tdata, 1);
    ifc.input_axis_tdata = 64'h2;
    #1;
    chk("bp_tready_low", ifc.input_axis_tready, 0);
    cyc();
    chk("bp_hold1", ifc.output_axis_tdata, 1);
    chk("bp_hold_v", ifc.output_axis_tvalid, 1);
    ifc.output_axis_tready = 1'b1;
    #1;
    chk("bp_tready_high", ifc.input_axis_tready, 1);
    cyc();
    chk("bp_out2", ifc.output_axis_tdata, 2);
    chk("bp_v2", ifc.output_axis_tvalid, 1);
    ifc.input_axis_tvalid = 1'b0;
    cyc();
    chk("bp_drain", ifc.output_axis_tvalid, 0);
    ifc.output_axis_tready = 1'b0;
    send(64'h3);
    chk("hl_out3", ifc.output_axis_tdata, 3);
    load(32'd100);
    cyc(); cyc();
    chk("hl_pend_busy", ifc.busy, 1);
    chk("hl_hold3", ifc.output_axis_tdata, 3);
    chk("hl_hold_v", ifc.output_axis_tvalid, 1);
    chk("hl_rej_kept", ifc.reject_count, 1);
    ifc.output_axis_tready = 1'b1;
    cyc();
    chk("hl_drained", ifc.output_axis_tvalid, 0);
    chk("hl_rej_clr", ifc.reject_count, 0);
    busy_len("busy_len_100", 8);
    send(64'hFF);
    chk("b100_rej1", ifc.reject_count, 1);
    send(64'h64);
    chk("b100_eq", ifc.output_axis_tdata, 100);
    chk("b100_eq_v", ifc.output_axis_tvalid, 1);
    send(64'h65);
    chk("b100_over_v", ifc.output_axis_tvalid, 0);
    chk("b100_rej2", ifc.reject_count, 2);
    load(32'd0);
    busy_len("busy_len_0", 2);
    send(64'hFFFFFFFF);
    chk("b0_out_a", ifc.output_axis_tdata, 0);
    chk("b0_v_a", ifc.output_axis_tvalid, 1);
    send(64'h12345);
    chk("b0_out_b", ifc.output_axis_tdata, 0);
    chk("b0_v_b", ifc.output_axis_tvalid, 1);
    chk("b0_rej", ifc.reject_count, 0);
    load(32'hFFFFFFFF);
    busy_len("busy_len_max", 34);
    send(64'hDEADBEEF_CAFEF00D);
    chk("bmax_out", ifc.output_axis_tdata, 64'hCAFEF00D);
    chk("bmax_rej", ifc.reject_count, 0);
    load(32'd5);
    cyc();
    load(32'd1);
    busy_len("busy_len_dbl", 3);
    send(64'h2);
    chk("dbl_out0", ifc.output_axis_tdata, 0);
    chk("dbl_v0", ifc.output_axis_tvalid, 1);
    send(64'h3);
    chk("dbl_out1", ifc.output_axis_tdata, 1);
    chk("dbl_rej", ifc.reject_count, 0);
    load(32'd2);
    busy_len("busy_len_2", 4);
    send(64'h3);
    chk("b2_rej", ifc.reject_count, 1);
    ifc.output_axis_tready = 1'b0;
    send(64'h2);
    chk("b2_out2", ifc.output_axis_tdata, 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tvalid", ifc.output_axis_tvalid, 0);
    chk("mid_rst_tdata", ifc.output_axis_tdata, 0);
    chk("mid_rst_rej", ifc.reject_count, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_tready", ifc.input_axis_tready, 0);
    rst = 1'b1;
    ifc.output_axis_tready = 1'b1;
    load(32'hFFFFFFFF);
    cyc(); cyc(); cyc();
    chk("calc_busy", ifc.busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("calc_rst_busy", ifc.busy, 0);
    rst = 1'b1;
    ifc.input_axis_tdata = 64'h5;
    ifc.input_axis_tvalid = 1'b1;
    cyc(); cyc();
    chk("post_rst_tready", ifc.input_axis_tready, 0);
    chk("post_rst_tvalid", ifc.output_axis_tvalid, 0);
    ifc.input_axis_tvalid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
